garbage_queue_ctrl: RTL and testbench

- Multiplayer garbage scheduler between the network link, line-clear logic and playfield row-insert datapath.
- Queues incoming garbage packets from the opponent.
- On each local piece lock, converts cleared lines to attack lines, cancels attack against pending garbage, sends any remainder to the opponent, and otherwise sequences row insertions into the local playfield.
- Active only while the screen FSM is in multiplayer mode.

---
 rtl/garbage_queue_ctrl_pkg.sv | 31 +++
 rtl/garbage_queue_ctrl_fifo.sv | 60 ++++++
 rtl/garbage_queue_ctrl.sv | 171 +++++++++++++++++
 tb/tb_garbage_queue_ctrl.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/garbage_queue_ctrl_pkg.sv
// Shared types and helpers for the multiplayer garbage scheduler.
// Queue entries, controller state encoding and the line-clear to attack table.
package garbage_queue_ctrl_pkg;

  localparam int GARBAGE_QUEUE_DEPTH = 8;

  typedef struct packed {
    logic [3:0] lines;
    logic [3:0] hole;
  } garbage_entry_t;

  typedef enum logic [1:0] {
    GQ_IDLE,
    GQ_CANCEL,
    GQ_SEND,
    GQ_INSERT
  } garbage_state_t;

  // Clears beyond a tetris still count as a tetris.
  function automatic logic [3:0] attack_lines(input logic [2:0] cleared);
    logic [3:0] atk;
    case (cleared)
      3'd0, 3'd1: atk = 4'd0;
      3'd2:       atk = 4'd1;
      3'd3:       atk = 4'd2;
      default:    atk = 4'd4;
    endcase
    return atk;
  endfunction

endpackage

// File: rtl/garbage_queue_ctrl_fifo.sv
// Circular buffer of pending garbage packets.
// Besides push/pop it lets the controller rewrite the row count of the head entry.
module garbage_fifo
  import garbage_queue_ctrl_pkg::*;
#(
  parameter int DEPTH = GARBAGE_QUEUE_DEPTH
) (
  input  logic           clk,
  input  logic           rst_l,
  input  logic           flush,
  input  logic           push,
  input  garbage_entry_t push_data,
  input  logic           pop,
  input  logic           head_wr,
  input  logic [3:0]     head_lines,
  output garbage_entry_t head,
  output logic           full,
  output logic           empty
);

  localparam int AW = $clog2(DEPTH);

  garbage_entry_t mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;
  logic           do_hwr;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign do_hwr  = head_wr && !empty && !flush && !pop;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Push and head rewrite never share a slot: that needs the queue to be both empty and full.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
    if (do_hwr)  mem[rd_ptr].lines <= head_lines;
  end

endmodule

// File: rtl/garbage_queue_ctrl.sv
// Garbage scheduler: queues opponent packets, cancels them with local attacks,
// forwards leftover attack to the network and feeds garbage rows to the playfield.
module garbage_queue_ctrl
  import garbage_queue_ctrl_pkg::*;
#(
  parameter int QUEUE_DEPTH         = GARBAGE_QUEUE_DEPTH,
  parameter int MAX_INSERT_PER_LOCK = 8,
  parameter int PLAYFIELD_COLS      = 10
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       mp_active,
  input  logic       game_start,
  input  logic       game_end,
  input  logic       lock_valid,
  input  logic [2:0] lock_lines,
  input  logic       recv_valid,
  input  logic [3:0] recv_lines,
  input  logic [3:0] recv_hole,
  output logic       send_valid,
  output logic [3:0] send_lines,
  input  logic       send_ready,
  output logic       insert_valid,
  output logic [3:0] insert_hole,
  input  logic       insert_ready,
  output logic [6:0] pending_lines,
  output logic       busy,
  output logic       overflow,
  output logic       protocol_err
);

  localparam int         BW       = $clog2(MAX_INSERT_PER_LOCK + 1);
  localparam logic [3:0] LAST_COL = 4'(PLAYFIELD_COLS - 1);

  garbage_state_t state, state_d;
  logic [3:0]     remaining, remaining_d;
  logic [BW-1:0]  budget, budget_d;
  logic           flush;
  logic           lock_take;
  logic [3:0]     attack;
  logic           push;
  logic           fifo_full;
  logic           fifo_empty;
  garbage_entry_t push_data;
  garbage_entry_t head;
  logic           pop;
  logic           head_wr;
  logic [3:0]     head_lines_new;
  logic [3:0]     consumed;
  logic           insert_take;
  logic [6:0]     pending_d;

  assign flush     = game_start | game_end;
  assign lock_take = lock_valid && mp_active && (state == GQ_IDLE);
  assign attack    = attack_lines(lock_lines);
  assign push      = recv_valid && mp_active && (recv_lines != 4'd0) && !flush;

  assign push_data.lines = recv_lines;
  assign push_data.hole  = (recv_hole > LAST_COL) ? LAST_COL : recv_hole;

  garbage_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_l      (rst_l),
    .flush      (flush),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .head_wr    (head_wr),
    .head_lines (head_lines_new),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign busy         = (state != GQ_IDLE);
  assign send_valid   = (state == GQ_SEND);
  assign send_lines   = send_valid ? remaining : 4'd0;
  assign insert_valid = (state == GQ_INSERT) && !fifo_empty && (budget < BW'(MAX_INSERT_PER_LOCK));
  assign insert_hole  = insert_valid ? head.hole : 4'd0;
  assign insert_take  = insert_valid && insert_ready;

  always_comb begin
    state_d        = state;
    remaining_d    = remaining;
    budget_d       = budget;
    pop            = 1'b0;
    head_wr        = 1'b0;
    head_lines_new = head.lines;
    consumed       = 4'd0;
    unique case (state)
      GQ_IDLE: begin
        if (lock_take) begin
          remaining_d = attack;
          budget_d    = '0;
          if (attack != 4'd0)          state_d = GQ_CANCEL;
          else if (lock_lines == 3'd0) state_d = GQ_INSERT;
        end
      end
      // A clearing lock never receives garbage, so a fully spent attack returns to idle.
      GQ_CANCEL: begin
        if (fifo_empty) begin
          state_d = GQ_SEND;
        end else if (remaining >= head.lines) begin
          pop         = 1'b1;
          consumed    = head.lines;
          remaining_d = remaining - head.lines;
          if (remaining == head.lines) state_d = GQ_IDLE;
        end else begin
          head_wr        = 1'b1;
          head_lines_new = head.lines - remaining;
          consumed       = remaining;
          remaining_d    = 4'd0;
          state_d        = GQ_IDLE;
        end
      end
      GQ_SEND: begin
        if (send_ready) begin
          remaining_d = 4'd0;
          state_d     = GQ_IDLE;
        end
      end
      GQ_INSERT: begin
        if (!insert_valid) begin
          state_d = GQ_IDLE;
        end else if (insert_ready) begin
          budget_d = budget + 1'b1;
          if (head.lines == 4'd1) begin
            pop = 1'b1;
          end else begin
            head_wr        = 1'b1;
            head_lines_new = head.lines - 4'd1;
          end
        end
      end
      default: state_d = GQ_IDLE;
    endcase
  end

  assign pending_d = pending_lines
                   + ((push && !fifo_full) ? {3'd0, recv_lines} : 7'd0)
                   - {3'd0, consumed}
                   - {6'd0, insert_take};

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state         <= GQ_IDLE;
      remaining     <= 4'd0;
      budget        <= '0;
      pending_lines <= 7'd0;
      overflow      <= 1'b0;
      protocol_err  <= 1'b0;
    end else if (flush) begin
      state         <= GQ_IDLE;
      remaining     <= 4'd0;
      budget        <= '0;
      pending_lines <= 7'd0;
      if (game_start) begin
        overflow     <= 1'b0;
        protocol_err <= 1'b0;
      end
    end else begin
      state         <= state_d;
      remaining     <= remaining_d;
      budget        <= budget_d;
      pending_lines <= pending_d;
      if (push && fifo_full) overflow <= 1'b1;
      if (lock_valid && mp_active && (state != GQ_IDLE)) protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_garbage_queue_ctrl.sv
// Self-checking bench for garbage_queue_ctrl against a queue-of-packets reference model.
// Directed scenarios from the feature list plus randomized receive/lock sequences.
module tb_garbage_queue_ctrl;

  logic       clk = 1'b0;
  logic       rst_l;
  logic       mp_active, game_start, game_end;
  logic       lock_valid;
  logic [2:0] lock_lines;
  logic       recv_valid;
  logic [3:0] recv_lines, recv_hole;
  logic       send_valid, send_ready;
  logic [3:0] send_lines;
  logic       insert_valid, insert_ready;
  logic [3:0] insert_hole;
  logic [6:0] pending_lines;
  logic       busy, overflow, protocol_err;

  typedef struct {
    int lines;
    int hole;
  } pkt_t;

  pkt_t q[$];
  int   model_ovf  = 0;
  int   model_perr = 0;
  int   errors     = 0;
  int   checks     = 0;

  always #5 clk = ~clk;

  garbage_queue_ctrl dut (
    .clk           (clk),
    .rst_l         (rst_l),
    .mp_active     (mp_active),
    .game_start    (game_start),
    .game_end      (game_end),
    .lock_valid    (lock_valid),
    .lock_lines    (lock_lines),
    .recv_valid    (recv_valid),
    .recv_lines    (recv_lines),
    .recv_hole     (recv_hole),
    .send_valid    (send_valid),
    .send_lines    (send_lines),
    .send_ready    (send_ready),
    .insert_valid  (insert_valid),
    .insert_hole   (insert_hole),
    .insert_ready  (insert_ready),
    .pending_lines (pending_lines),
    .busy          (busy),
    .overflow      (overflow),
    .protocol_err  (protocol_err)
  );

  function automatic int model_sum();
    int s = 0;
    foreach (q[i]) s += q[i].lines;
    return s;
  endfunction

  function automatic int attack_of(input int l);
    if (l >= 4) return 4;
    if (l == 3) return 2;
    if (l == 2) return 1;
    return 0;
  endfunction

  function automatic void model_recv(input int lines, input int hole);
    pkt_t p;
    if (lines == 0) return;
    if (q.size() == 8) begin
      model_ovf = 1;
      return;
    end
    p.lines = lines;
    p.hole  = (hole >= 10) ? 9 : hole;
    q.push_back(p);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_recv(input int lines, input int hole);
    recv_valid = 1'b1;
    recv_lines = 4'(lines);
    recv_hole  = 4'(hole);
    model_recv(lines, hole);
    tick();
    recv_valid = 1'b0;
  endtask

  task automatic do_flush(input bit start);
    game_start = start;
    game_end   = !start;
    tick();
    game_start = 1'b0;
    game_end   = 1'b0;
    q.delete();
    if (start) begin
      model_ovf  = 0;
      model_perr = 0;
    end
  endtask

  // Drives one lock and the resulting handshakes; the model predicts cancel/send/insert outcome.
  task automatic run_lock(input int ll, input bit with_recv, input int rl, input int rh,
                          input int ins_pct, input int send_delay, input bit poke_lock,
                          output int n_ins, output int exp_ins, output int n_send,
                          output int exp_send, output int send_val, output int send_cycles,
                          output int bad, output bit timed_out);
    int a;
    int cyc;
    bit rdy;
    n_ins = 0; n_send = 0; send_val = -1; send_cycles = 0; bad = 0; timed_out = 0;
    exp_send = -1; exp_ins = 0;
    if (with_recv) begin
      recv_valid = 1'b1;
      recv_lines = 4'(rl);
      recv_hole  = 4'(rh);
      model_recv(rl, rh);
    end
    lock_valid = 1'b1;
    lock_lines = 3'(ll);
    a = attack_of(ll);
    if (a > 0) begin
      while (a > 0 && q.size() > 0) begin
        if (a >= q[0].lines) begin
          a -= q[0].lines;
          void'(q.pop_front());
        end else begin
          q[0].lines -= a;
          a = 0;
        end
      end
      if (a > 0) exp_send = a;
    end else if (ll == 0) begin
      exp_ins = (model_sum() < 8) ? model_sum() : 8;
    end
    tick();
    lock_valid = 1'b0;
    recv_valid = 1'b0;
    cyc = 0;
    while (busy && cyc < 300) begin
      insert_ready = 1'b0;
      send_ready   = 1'b0;
      lock_valid   = 1'b0;
      if (insert_valid) begin
        if (q.size() == 0 || int'(insert_hole) != q[0].hole) bad++;
        rdy = ($urandom_range(0, 99) < ins_pct);
        insert_ready = rdy;
        if (rdy) begin
          n_ins++;
          if (q.size() > 0) begin
            q[0].lines--;
            if (q[0].lines == 0) void'(q.pop_front());
          end
        end
      end
      if (send_valid) begin
        if (send_cycles == 0) send_val = int'(send_lines);
        else if (int'(send_lines) != send_val) bad++;
        rdy = (send_cycles >= send_delay);
        send_ready = rdy;
        send_cycles++;
        if (rdy) n_send++;
        if (poke_lock && send_cycles == 1) begin
          lock_valid = 1'b1;
          lock_lines = 3'd2;
          model_perr = 1;
        end
      end
      tick();
      cyc++;
    end
    insert_ready = 1'b0;
    send_ready   = 1'b0;
    lock_valid   = 1'b0;
    if (busy) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    #12;
    checks++;
    if ({send_valid, send_lines, insert_valid, insert_hole, pending_lines, busy, overflow, protocol_err} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b want all zero",
               {send_valid, send_lines, insert_valid, insert_hole, pending_lines, busy, overflow, protocol_err});
    end
    @(negedge clk);
    rst_l = 1'b1;
    tick();
    do_recv(5, 3);
    checks++;
    if (int'(pending_lines) != 5) begin
      errors++;
      $display("[TB] FAIL reset_pre_pending: got %0d want 5", pending_lines);
    end
    rst_l = 1'b0;
    #2;
    checks++;
    if (pending_lines !== 7'd0) begin
      errors++;
      $display("[TB] FAIL reset_async_pending: got %0d want 0", pending_lines);
    end
    q.delete();
    @(negedge clk);
    rst_l = 1'b1;
    tick();
  endtask

  task automatic test_insert_basic();
    int n_ins, exp_ins, n_send, exp_send, sv, sc, bad;
    bit to;
    do_flush(1'b1);
    do_recv(3, 4);
    checks++;
    if (int'(pending_lines) != 3) begin
      errors++;
      $display("[TB] FAIL insert_basic_pending_before: got %0d want 3", pending_lines);
    end
    run_lock(0, 0, 0, 0, 100, 0, 0, n_ins, exp_ins, n_send, exp_send, sv, sc, bad, to);
    checks++;
    if (n_ins != 3 || bad != 0 || to) begin
      errors++;
      $display("[TB] FAIL insert_basic_rows: got n=%0d bad=%0d to=%0d want n=3 bad=0 to=0", n_ins, bad, to);
    end
    checks++;
    if (pending_lines !== 7'd0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL insert_basic_after: got pending=%0d busy=%0b want 0/0", pending_lines, busy);
    end
  endtask

  task automatic test_cancel_partial();
    int n_ins, exp_ins, n_send, exp_send, sv, sc, bad;
    bit to;
    do_flush(1'b1);
    do_recv(2, 1);
    do_recv(3, 7);
    run_lock(4, 0, 0, 0, 100, 0, 0, n_ins, exp_ins, n_send, exp_send, sv, sc, bad, to);
    checks++;
    if (n_send != 0 || sc != 0 || to) begin
      errors++;
      $display("[TB] FAIL cancel_no_send: got sends=%0d cycles=%0d to=%0d want 0/0/0", n_send, sc, to);
    end
    checks++;
    if (int'(pending_lines) != 1) begin
      errors++;
      $display("[TB] FAIL cancel_pending: got %0d want 1", pending_lines);
    end
    run_lock(0, 0, 0, 0, 100, 0, 0, n_ins, exp_ins, n_send, exp_send, sv, sc, bad, to);
    checks++;
    if (n_ins != 1 || bad != 0) begin
      errors++;
      $display("[TB] FAIL cancel_head_left: got n=%0d bad=%0d want n=1 hole 7", n_ins, bad);
    end
  endtask

  task automatic test_send_stall();
    int n_ins, exp_ins, n_send, exp_send, sv, sc, bad;
    bit to;
    do_flush(1'b1);
    run_lock(3, 0, 0, 0, 100, 5, 0, n_ins, exp_ins, n_send, exp_send, sv, sc, bad, to);
    checks++;
    if (sc != 6 || sv != 2 || n_send != 1 || bad != 0 || to) begin
      errors++;
      $display("[TB] FAIL send_stall: got cycles=%0d lines=%0d sends=%0d bad=%0d want 6/2/1/0", sc, sv, n_send, bad);
    end
    checks++;
    if (busy !== 1'b0 || send_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL send_stall_idle: got busy=%0b valid=%0b want 0/0", busy, send_valid);
    end
  endtask

  task automatic test_insert_budget();
    int n_ins, exp_ins, n_send, exp_send, sv, sc, bad;
    bit to;
    do_flush(1'b1);
    do_recv(15, 0);
    run_lock(0, 0, 0, 0, 50, 0, 0, n_ins, exp_ins, n_send, exp_send, sv, sc, bad, to);
    checks++;
    if (n_ins != 8 || bad != 0 || to || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL budget_rows: got n=%0d bad=%0d busy=%0b want n=8 bad=0 busy=0", n_ins, bad, busy);
    end
    checks++;
    if (int'(pending_lines) != 7) begin
      errors++;
      $display("[TB] FAIL budget_pending: got %0d want 7", pending_lines);
    end
    run_lock(0, 0, 0, 0, 100, 0, 0, n_ins, exp_ins, n_send, exp_send, sv, sc, bad, to);
    checks++;
    if (n_ins != 7 || bad != 0) begin
      errors++;
      $display("[TB] FAIL budget_remainder: got n=%0d bad=%0d want n=7 hole 0", n_ins, bad);
    end
  endtask

  task automatic test_overflow_flush();
    do_flush(1'b1);
    for (int i = 0; i < 8; i++) do_recv(2, i);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overflow_early: got %0b want 0", overflow);
    end
    do_recv(4, 2);
    checks++;
    if (overflow !== 1'b1 || int'(pending_lines) != 16) begin
      errors++;
      $display("[TB] FAIL overflow_drop: got ovf=%0b pending=%0d want 1/16", overflow, pending_lines);
    end
    lock_valid = 1'b1;
    lock_lines = 3'd0;
    tick();
    lock_valid   = 1'b0;
    insert_ready = 1'b1;
    tick();
    tick();
    game_end   = 1'b1;
    recv_valid = 1'b1;
    recv_lines = 4'd5;
    recv_hole  = 4'd1;
    tick();
    game_end     = 1'b0;
    recv_valid   = 1'b0;
    insert_ready = 1'b0;
    q.delete();
    checks++;
    if (insert_valid !== 1'b0 || pending_lines !== 7'd0 || busy !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL game_end_flush: got iv=%0b pending=%0d busy=%0b ovf=%0b want 0/0/0/1",
               insert_valid, pending_lines, busy, overflow);
    end
    do_flush(1'b1);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL game_start_clear: got ovf=%0b want 0", overflow);
    end
  endtask

  task automatic test_protocol_err();
    int n_ins, exp_ins, n_send, exp_send, sv, sc, bad;
    bit to;
    do_flush(1'b1);
    run_lock(4, 0, 0, 0, 100, 2, 1, n_ins, exp_ins, n_send, exp_send, sv, sc, bad, to);
    checks++;
    if (protocol_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL protocol_err_flag: got %0b want 1", protocol_err);
    end
    checks++;
    if (sv != 4 || sc != 3 || n_send != 1 || bad != 0 || to || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL protocol_send: got lines=%0d cycles=%0d sends=%0d bad=%0d want 4/3/1/0", sv, sc, n_send, bad);
    end
  endtask

  task automatic test_mp_inactive();
    do_flush(1'b1);
    mp_active  = 1'b0;
    recv_valid = 1'b1;
    recv_lines = 4'd5;
    recv_hole  = 4'd2;
    tick();
    recv_valid = 1'b0;
    lock_valid = 1'b1;
    lock_lines = 3'd4;
    tick();
    lock_valid = 1'b0;
    checks++;
    if (pending_lines !== 7'd0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mp_inactive: got pending=%0d busy=%0b want 0/0", pending_lines, busy);
    end
    mp_active = 1'b1;
  endtask

  task automatic test_random();
    int n_ins, exp_ins, n_send, exp_send, sv, sc, bad;
    bit to;
    do_flush(1'b1);
    for (int it = 0; it < 40; it++) begin
      if (it % 9 == 8) do_flush($urandom_range(0, 1) == 1);
      for (int r = 0; r < int'($urandom_range(0, 3)); r++)
        do_recv(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      run_lock(int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, int'($urandom_range(1, 15)),
               int'($urandom_range(0, 15)), int'($urandom_range(30, 100)), int'($urandom_range(0, 3)), 0,
               n_ins, exp_ins, n_send, exp_send, sv, sc, bad, to);
      checks++;
      if (to || bad != 0 || n_ins != exp_ins) begin
        errors++;
        $display("[TB] FAIL random_insert it=%0d: got n=%0d bad=%0d to=%0d want n=%0d", it, n_ins, bad, to, exp_ins);
      end
      checks++;
      if ((exp_send < 0 && n_send != 0) || (exp_send >= 0 && (n_send != 1 || sv != exp_send))) begin
        errors++;
        $display("[TB] FAIL random_send it=%0d: got sends=%0d lines=%0d want lines=%0d", it, n_send, sv, exp_send);
      end
      checks++;
      if (int'(pending_lines) != model_sum() || int'(overflow) != model_ovf || int'(protocol_err) != model_perr) begin
        errors++;
        $display("[TB] FAIL random_state it=%0d: got pending=%0d ovf=%0b perr=%0b want %0d/%0d/%0d",
                 it, pending_lines, overflow, protocol_err, model_sum(), model_ovf, model_perr);
      end
    end
  endtask

  initial begin
    mp_active    = 1'b1;
    game_start   = 1'b0;
    game_end     = 1'b0;
    lock_valid   = 1'b0;
    lock_lines   = 3'd0;
    recv_valid   = 1'b0;
    recv_lines   = 4'd0;
    recv_hole    = 4'd0;
    send_ready   = 1'b0;
    insert_ready = 1'b0;
    test_reset();
    test_insert_basic();
    test_cancel_partial();
    test_send_stall();
    test_insert_budget();
    test_overflow_flush();
    test_protocol_err();
    test_mp_inactive();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
